// File: rtl/wb_regfile_pkg.sv
// ============================================================================
// wb_regfile_pkg
// ----------------------------------------------------------------------------
// Shared constants for the write-back register file slice.
//   rwidth   : register-address width
//   word     : data width
//   ZERO_REG : address of the hardwired-zero register
//   NUM_REGS : architectural register count (including $0)
// The optional same-cycle bypass in wb_regfile is enabled by defining the
// macro WB_REGFILE_BYPASS_EN; nothing in this package depends on it.
// ============================================================================
package wb_regfile_pkg;

    localparam int rwidth   = 5;
    localparam int word     = 32;
    localparam int NUM_REGS = 32;

    localparam logic [4:0] ZERO_REG = 5'd0;

    // Write-back source selector encoding, mirrors the WB_MemtoReg control bit.
    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    // Snapshot of the qualified write port, handy for binding checkers.
    typedef struct packed {
        logic            en;
        logic [4:0]      addr;
        logic [word-1:0] data;
    } wb_commit_t;

    // True when a write-back request really lands in the register file.
    function automatic logic wb_commits(input logic reg_write,
                                        input logic [4:0] dest);
        return reg_write && (dest != ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_regfile_array.sv
// ============================================================================
// wb_regfile_array
// ----------------------------------------------------------------------------
// Storage for the general-purpose registers $1..$(2**rwidth-1). Register $0 has
// no storage: reads of address 0 return zero and writes to it are dropped.
//
// Ports:
//   Clock       in   system clock, all updates on posedge
//   Reset       in   synchronous active-high reset, clears every register
//   wr_en       in   commit strobe (already qualified by the caller)
//   wr_addr     in   destination register
//   wr_data     in   data to commit
//   rd_addr_1   in   read address, port 1
//   rd_addr_2   in   read address, port 2
//   rd_data_1   out  combinational read data, port 1
//   rd_data_2   out  combinational read data, port 2
// ============================================================================
module wb_regfile_array #(
    parameter int rwidth = wb_regfile_pkg::rwidth,
    parameter int word   = wb_regfile_pkg::word
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [rwidth-1:0] wr_addr,
    input  logic [word-1:0]   wr_data,
    input  logic [rwidth-1:0] rd_addr_1,
    input  logic [rwidth-1:0] rd_addr_2,
    output logic [word-1:0]   rd_data_1,
    output logic [word-1:0]   rd_data_2
);
    import wb_regfile_pkg::*;

    localparam int depth = 2 ** rwidth;
    localparam logic [rwidth-1:0] zero_addr = rwidth'(ZERO_REG);

    // Index 0 is intentionally absent; $0 is synthesised as a constant.
    logic [word-1:0] regs [1:depth-1];

    // Reset wins over a simultaneous write. The $0 guard is repeated here so
    // the array is safe even if a caller forgets to qualify the strobe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 1; i < depth; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != zero_addr)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_1 = '0;
        if (rd_addr_1 != zero_addr) begin
            rd_data_1 = regs[rd_addr_1];
        end
    end

    always_comb begin
        rd_data_2 = '0;
        if (rd_addr_2 != zero_addr) begin
            rd_data_2 = regs[rd_addr_2];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// ============================================================================
// wb_regfile
// ----------------------------------------------------------------------------
// Write-back end of the MEM/WB interface: picks the write-back value, commits
// it to the register file, serves the two ID-stage read ports and counts
// committed writes.
//
// Configuration macro: WB_REGFILE_BYPASS_EN
//   defined   : a read port whose address matches a committing write returns
//               WB_Write_data in the same cycle (WB-to-ID bypass).
//   undefined : read ports show array contents only (old value on a
//               same-cycle read of the register being written).
//
// Ports:
//   Clock                     in   system clock
//   Reset                     in   synchronous active-high reset
//   WB_RegWrite               in   write enable from MEM/WB
//   WB_MemtoReg               in   1 = memory data, 0 = ALU result
//   WB_Data_memory_Read_data  in   load data
//   WB_ALU_result             in   ALU result
//   WB_MUX8_out               in   destination register
//   ID_Read_register_1/2      in   read addresses
//   ID_Read_data_1/2          out  combinational read data
//   WB_Write_data             out  selected write-back value (combinational)
//   WB_Write_count            out  committed-write count, wraps at 2**word
//
// There is no handshake on this block: every cycle with WB_RegWrite high and
// a non-zero destination is a commit; there is no backpressure.
// ============================================================================
module wb_regfile #(
    parameter int rwidth = wb_regfile_pkg::rwidth,
    parameter int word   = wb_regfile_pkg::word
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WB_RegWrite,
    input  logic              WB_MemtoReg,
    input  logic [word-1:0]   WB_Data_memory_Read_data,
    input  logic [word-1:0]   WB_ALU_result,
    input  logic [rwidth-1:0] WB_MUX8_out,
    input  logic [rwidth-1:0] ID_Read_register_1,
    input  logic [rwidth-1:0] ID_Read_register_2,
    output logic [word-1:0]   ID_Read_data_1,
    output logic [word-1:0]   ID_Read_data_2,
    output logic [word-1:0]   WB_Write_data,
    output logic [word-1:0]   WB_Write_count
);
    import wb_regfile_pkg::*;

    localparam logic [rwidth-1:0] zero_addr = rwidth'(ZERO_REG);

    logic            commit;
    logic [word-1:0] array_rd_1;
    logic [word-1:0] array_rd_2;
    logic [word-1:0] write_count;
    logic [word-1:0] count_next;

    // ---------------------------------------------------------------- select
    always_comb begin
        WB_Write_data = WB_ALU_result;
        if (wb_src_e'(WB_MemtoReg) == WB_SRC_MEM) begin
            WB_Write_data = WB_Data_memory_Read_data;
        end
    end

    // Writes aimed at $0 are architecturally no-ops and are not counted.
    assign commit = WB_RegWrite && (WB_MUX8_out != zero_addr);

    // ----------------------------------------------------------------- array
    wb_regfile_array #(
        .rwidth (rwidth),
        .word   (word)
    ) u_array (
        .Clock     (Clock),
        .Reset     (Reset),
        .wr_en     (commit),
        .wr_addr   (WB_MUX8_out),
        .wr_data   (WB_Write_data),
        .rd_addr_1 (ID_Read_register_1),
        .rd_addr_2 (ID_Read_register_2),
        .rd_data_1 (array_rd_1),
        .rd_data_2 (array_rd_2)
    );

    // ---------------------------------------------------------------- bypass
`ifdef WB_REGFILE_BYPASS_EN
    // commit already excludes $0, so a read of address 0 never bypasses.
    always_comb begin
        ID_Read_data_1 = array_rd_1;
        if (commit && (ID_Read_register_1 == WB_MUX8_out)) begin
            ID_Read_data_1 = WB_Write_data;
        end
    end

    always_comb begin
        ID_Read_data_2 = array_rd_2;
        if (commit && (ID_Read_register_2 == WB_MUX8_out)) begin
            ID_Read_data_2 = WB_Write_data;
        end
    end
`else
    assign ID_Read_data_1 = array_rd_1;
    assign ID_Read_data_2 = array_rd_2;
`endif

    // --------------------------------------------------------------- counter
    // Next-state kept as its own net so the increment path is easy to observe.
    assign count_next = write_count + 1'b1;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            write_count <= '0;
        end else if (commit) begin
            write_count <= count_next;
        end
    end

    assign WB_Write_count = write_count;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    localparam int rwidth = 5;
    localparam int word   = 32;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit bypass_on = 1'b1;
`else
    localparam bit bypass_on = 1'b0;
`endif

    // ------------------------------------------------------ clock and reset
    logic              Clock = 1'b0;
    logic              Reset;
    logic              WB_RegWrite;
    logic              WB_MemtoReg;
    logic [word-1:0]   WB_Data_memory_Read_data;
    logic [word-1:0]   WB_ALU_result;
    logic [rwidth-1:0] WB_MUX8_out;
    logic [rwidth-1:0] ID_Read_register_1;
    logic [rwidth-1:0] ID_Read_register_2;
    logic [word-1:0]   ID_Read_data_1;
    logic [word-1:0]   ID_Read_data_2;
    logic [word-1:0]   WB_Write_data;
    logic [word-1:0]   WB_Write_count;

    always #5 Clock = ~Clock;

    wb_regfile dut (
        .Clock                    (Clock),
        .Reset                    (Reset),
        .WB_RegWrite              (WB_RegWrite),
        .WB_MemtoReg              (WB_MemtoReg),
        .WB_Data_memory_Read_data (WB_Data_memory_Read_data),
        .WB_ALU_result            (WB_ALU_result),
        .WB_MUX8_out              (WB_MUX8_out),
        .ID_Read_register_1       (ID_Read_register_1),
        .ID_Read_register_2       (ID_Read_register_2),
        .ID_Read_data_1           (ID_Read_data_1),
        .ID_Read_data_2           (ID_Read_data_2),
        .WB_Write_data            (WB_Write_data),
        .WB_Write_count           (WB_Write_count)
    );

    // ----------------------------------------------------------- scoreboard
    logic [word-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic expect_val(input logic [word-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [word-1:0] obs);
        logic [word-1:0] exp;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // --------------------------------------------------------- driver tasks
    // Inputs change 1 time unit after the rising edge; checks happen 1 unit
    // after that, well clear of the next edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_idle();
        WB_RegWrite              = 1'b0;
        WB_MemtoReg              = 1'b0;
        WB_ALU_result            = word'($urandom_range(0, 32'h7FFF_FFFF));
        WB_Data_memory_Read_data = word'($urandom_range(0, 32'h7FFF_FFFF));
        WB_MUX8_out              = rwidth'($urandom_range(0, 31));
    endtask

    task automatic drive_write(input logic mem, input logic [rwidth-1:0] dest,
                               input logic [word-1:0] value);
        WB_RegWrite = 1'b1;
        WB_MemtoReg = mem;
        WB_MUX8_out = dest;
        if (mem) begin
            WB_Data_memory_Read_data = value;
            WB_ALU_result            = word'($urandom_range(0, 32'h7FFF_FFFF));
        end else begin
            WB_ALU_result            = value;
            WB_Data_memory_Read_data = word'($urandom_range(0, 32'h7FFF_FFFF));
        end
    endtask

    task automatic read_ports(input logic [rwidth-1:0] a1, input logic [rwidth-1:0] a2);
        ID_Read_register_1 = a1;
        ID_Read_register_2 = a2;
    endtask

    // ------------------------------------------------------------- watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------- stimulus
    initial begin
        Reset = 1'b1;
        drive_idle();
        read_ports('0, '0);
        tick();
        tick();
        Reset = 1'b0;
        settle();

        // After reset every address reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            read_ports(rwidth'(i), rwidth'(31 - i));
            settle();
            expect_val('0); check($sformatf("rst_rd1[%0d]", i), ID_Read_data_1);
            expect_val('0); check($sformatf("rst_rd2[%0d]", 31 - i), ID_Read_data_2);
        end
        expect_val('0); check("rst_count", WB_Write_count);

        // ALU result into $5.
        tick();
        drive_write(1'b0, 5'd5, 32'h0000_1234);
        read_ports(5'd1, 5'd2);
        settle();
        expect_val(32'h0000_1234); check("wdata_alu", WB_Write_data);
        tick();
        drive_idle();
        read_ports(5'd5, 5'd0);
        settle();
        expect_val(32'h0000_1234); check("r5_alu", ID_Read_data_1);
        expect_val(32'd1);         check("count_1", WB_Write_count);

        // Memory data into $5.
        drive_write(1'b1, 5'd5, 32'hDEAD_BEEF);
        read_ports(5'd1, 5'd2);
        settle();
        expect_val(32'hDEAD_BEEF); check("wdata_mem", WB_Write_data);
        tick();
        drive_idle();
        read_ports(5'd5, 5'd5);
        settle();
        expect_val(32'hDEAD_BEEF); check("r5_mem_p1", ID_Read_data_1);
        expect_val(32'hDEAD_BEEF); check("r5_mem_p2", ID_Read_data_2);
        expect_val(32'd2);         check("count_2", WB_Write_count);

        // Write to $0 is dropped, no bypass onto address 0 either.
        drive_write(1'b0, 5'd0, 32'hFFFF_FFFF);
        read_ports(5'd0, 5'd0);
        settle();
        expect_val('0); check("r0_same_cycle", ID_Read_data_1);
        tick();
        drive_idle();
        read_ports(5'd0, 5'd5);
        settle();
        expect_val('0);            check("r0_after", ID_Read_data_1);
        expect_val(32'hDEAD_BEEF); check("r5_kept", ID_Read_data_2);
        expect_val(32'd2);         check("count_r0", WB_Write_count);

        // Same-cycle read of the register being written.
        drive_write(1'b0, 5'd7, 32'h0000_0011);
        tick();
        drive_write(1'b0, 5'd7, 32'h0000_0022);
        read_ports(5'd7, 5'd7);
        settle();
        expect_val(bypass_on ? 32'h0000_0022 : 32'h0000_0011); check("r7_hazard_p1", ID_Read_data_1);
        expect_val(bypass_on ? 32'h0000_0022 : 32'h0000_0011); check("r7_hazard_p2", ID_Read_data_2);
        read_ports(5'd7, 5'd5);
        settle();
        expect_val(32'hDEAD_BEEF); check("r5_no_bypass", ID_Read_data_2);
        tick();
        drive_idle();
        read_ports(5'd7, 5'd7);
        settle();
        expect_val(32'h0000_0022); check("r7_next_p1", ID_Read_data_1);
        expect_val(32'h0000_0022); check("r7_next_p2", ID_Read_data_2);
        expect_val(32'd4);         check("count_4", WB_Write_count);

        // Reset wins over a write in the same cycle.
        drive_write(1'b0, 5'd3, 32'h0000_00AA);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        drive_idle();
        read_ports(5'd3, 5'd7);
        settle();
        expect_val('0); check("r3_after_rst", ID_Read_data_1);
        expect_val('0); check("r7_after_rst", ID_Read_data_2);
        expect_val('0); check("count_after_rst", WB_Write_count);

        // Counter wrap: preload the count to all-ones through its next-state
        // net during one commit, then let a normal commit wrap it.
        drive_write(1'b0, 5'd9, 32'h0000_0099);
        force dut.count_next = 32'hFFFF_FFFF;
        tick();
        release dut.count_next;
        drive_idle();
        read_ports(5'd9, 5'd0);
        settle();
        expect_val(32'hFFFF_FFFF); check("count_preload", WB_Write_count);
        expect_val(32'h0000_0099); check("r9", ID_Read_data_1);
        drive_write(1'b1, 5'd10, 32'h1010_1010);
        tick();
        drive_idle();
        read_ports(5'd10, 5'd9);
        settle();
        expect_val('0);            check("count_wrap", WB_Write_count);
        expect_val(32'h1010_1010); check("r10", ID_Read_data_1);
        expect_val(32'h0000_0099); check("r9_kept", ID_Read_data_2);

        // ------------------------------------------------------ final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
